// File: rtl/dram_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds FSM state encodings and latency counter sizing.
package dram_responder_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    DRAM_IDLE    = 2'd0,
    DRAM_RD_WAIT = 2'd1,
    DRAM_WR_DONE = 2'd2
  } dram_state_e;

  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dram_responder_array.sv
// Single-port storage: synchronous write, asynchronous read.
// Not reset; contents persist across Rst_n.
module dram_responder_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dram_responder.sv
// Data-memory responder: fixed-latency reads, one-cycle writes.
// DRAM_HOST_PORT_EN adds a low-priority host load/dump port.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             memREAD,
  input  logic             memWRITE,
  input  logic [WIDTH-1:0] DRAM_addr,
  input  logic [WIDTH-1:0] DRAM_dataOut,
  output logic [WIDTH-1:0] DRAM_dataIn,
  output logic             memRDY,
  output logic             busy,
  output logic             memERR
`ifdef DRAM_HOST_PORT_EN
  ,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic [WIDTH-1:0] host_rdata,
  output logic             host_gnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH:0] DEPTH_W = (WIDTH+1)'(DEPTH);

  if (DEPTH > (1 << WIDTH)) begin : g_bad_depth
    $error("DEPTH exceeds address space");
  end
  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_lat
    $error("READ_LAT out of range");
  end

  dram_state_e      state;
  logic [LAT_W-1:0] cnt;
  logic [WIDTH-1:0] addr_q;

  logic             idle;
  logic             strobe;
  logic             core_in;
  logic             q_in;
  logic             host_sel;

  logic             arr_we;
  logic [AW-1:0]    arr_addr;
  logic [WIDTH-1:0] arr_wdata;
  logic [WIDTH-1:0] arr_rdata;

  assign idle    = (state == DRAM_IDLE);
  assign busy    = ~idle;
  assign strobe  = memREAD | memWRITE;
  assign core_in = {1'b0, DRAM_addr} < DEPTH_W;
  assign q_in    = {1'b0, addr_q} < DEPTH_W;

`ifdef DRAM_HOST_PORT_EN
  logic host_in;
  assign host_in  = {1'b0, host_addr} < DEPTH_W;
  assign host_sel = idle & ~strobe & host_req;
`else
  assign host_sel = 1'b0;
`endif

  // One array port shared by core write, pending read and host
  always_comb begin
    arr_we    = 1'b0;
    arr_addr  = DRAM_addr[AW-1:0];
    arr_wdata = DRAM_dataOut;
    unique case (1'b1)
      !idle: begin
        arr_addr = addr_q[AW-1:0];
      end
      idle && memWRITE: begin
        arr_we = core_in;
      end
`ifdef DRAM_HOST_PORT_EN
      host_sel: begin
        arr_addr  = host_addr[AW-1:0];
        arr_wdata = host_wdata;
        arr_we    = host_we & host_in;
      end
`endif
      default: ;
    endcase
  end

  dram_responder_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (Clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= DRAM_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      DRAM_dataIn <= '0;
      memRDY      <= 1'b0;
      memERR      <= 1'b0;
`ifdef DRAM_HOST_PORT_EN
      host_rdata  <= '0;
      host_gnt    <= 1'b0;
`endif
    end else begin
      memRDY <= 1'b0;
`ifdef DRAM_HOST_PORT_EN
      host_gnt <= 1'b0;
`endif
      unique case (state)
        DRAM_IDLE: begin
          if (memWRITE) begin
            state <= DRAM_WR_DONE;
            if (memREAD || !core_in) memERR <= 1'b1;
          end else if (memREAD) begin
            addr_q <= DRAM_addr;
            cnt    <= lat_load(READ_LAT);
            state  <= DRAM_RD_WAIT;
            if (!core_in) memERR <= 1'b1;
          end
`ifdef DRAM_HOST_PORT_EN
          else if (host_req) begin
            host_gnt <= 1'b1;
            if (!host_we) host_rdata <= host_in ? arr_rdata : '0;
          end
`endif
        end
        DRAM_RD_WAIT: begin
          if (strobe) memERR <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
          end else begin
            DRAM_dataIn <= q_in ? arr_rdata : '0;
            memRDY      <= 1'b1;
            state       <= DRAM_IDLE;
          end
        end
        DRAM_WR_DONE: begin
          if (strobe) memERR <= 1'b1;
          memRDY <= 1'b1;
          state  <= DRAM_IDLE;
        end
        default: state <= DRAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: vector table, corner sequences, random vs model.
// Host-port checks run when DRAM_HOST_PORT_EN is defined.
module tb_dram_responder;

  localparam int RL  = 3;
  localparam int DEP = 128;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       memREAD = 1'b0;
  logic       memWRITE = 1'b0;
  logic [7:0] DRAM_addr = '0;
  logic [7:0] DRAM_dataOut = '0;
  logic [7:0] DRAM_dataIn;
  logic       memRDY;
  logic       busy;
  logic       memERR;
`ifdef DRAM_HOST_PORT_EN
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       host_gnt;
`endif

  dram_responder #(
    .WIDTH    (8),
    .DEPTH    (DEP),
    .READ_LAT (RL)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .memREAD      (memREAD),
    .memWRITE     (memWRITE),
    .DRAM_addr    (DRAM_addr),
    .DRAM_dataOut (DRAM_dataOut),
    .DRAM_dataIn  (DRAM_dataIn),
    .memRDY       (memRDY),
    .busy         (busy),
    .memERR       (memERR)
`ifdef DRAM_HOST_PORT_EN
    ,
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .host_gnt     (host_gnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem_m [DEP];
  logic [7:0] din_m = '0;
  bit         err_m = 1'b0;
  int         lat_m = 0;

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] din;
    bit         err;
    int         lat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    Rst_n = 1'b0;
    memREAD = 1'b0;
    memWRITE = 1'b0;
    #3;
    chk("rst_din", DRAM_dataIn, 0);
    chk("rst_rdy", memRDY, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", memERR, 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    err_m = 1'b0;
    din_m = '0;
  endtask

  // Issue one request for a single cycle and count cycles to memRDY
  task automatic do_txn(input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] d, output int lat);
    memREAD = rd;
    memWRITE = wr;
    DRAM_addr = a;
    DRAM_dataOut = d;
    @(posedge Clk);
    #1;
    memREAD = 1'b0;
    memWRITE = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_rdy", memRDY, 0);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk);
      #1;
      if (memRDY) begin
        lat = i;
        break;
      end
    end
    chk("done_busy", busy, 0);
  endtask

  task automatic model_step(input bit rd, input bit wr,
                            input logic [7:0] a, input logic [7:0] d);
    if (wr) begin
      lat_m = 1;
      if (int'(a) < DEP) mem_m[a[6:0]] = d;
      else err_m = 1'b1;
      if (rd) err_m = 1'b1;
    end else begin
      lat_m = RL;
      if (int'(a) < DEP) begin
        din_m = mem_m[a[6:0]];
      end else begin
        din_m = '0;
        err_m = 1'b1;
      end
    end
  endtask

  task automatic model_txn(input bit rd, input bit wr,
                           input logic [7:0] a, input logic [7:0] d);
    int lat;
    model_step(rd, wr, a, d);
    do_txn(rd, wr, a, d, lat);
    chk("m_lat", lat, lat_m);
    chk("m_din", DRAM_dataIn, din_m);
    chk("m_err", memERR, err_m);
  endtask

  initial begin
    int lat;
    int rdy_seen;
    tbl[0]  = '{0, 1, 8'h20, 8'hA7, 8'h00, 0, 1};
    tbl[1]  = '{1, 0, 8'h20, 8'h00, 8'hA7, 0, RL};
    tbl[2]  = '{0, 1, 8'h21, 8'h11, 8'hA7, 0, 1};
    tbl[3]  = '{1, 0, 8'h21, 8'h00, 8'h11, 0, RL};
    tbl[4]  = '{0, 1, 8'h10, 8'hC4, 8'h11, 0, 1};
    tbl[5]  = '{0, 1, 8'h7F, 8'h66, 8'h11, 0, 1};
    tbl[6]  = '{1, 0, 8'h7F, 8'h00, 8'h66, 0, RL};
    tbl[7]  = '{0, 1, 8'h90, 8'hFF, 8'h66, 1, 1};
    tbl[8]  = '{1, 0, 8'h90, 8'h00, 8'h00, 1, RL};
    tbl[9]  = '{1, 0, 8'h10, 8'h00, 8'hC4, 1, RL};
    tbl[10] = '{1, 1, 8'h05, 8'h33, 8'hC4, 1, 1};
    tbl[11] = '{1, 0, 8'h05, 8'h00, 8'h33, 1, RL};

    #12;
    reset_dut();

    // Contents survive reset
    do_txn(0, 1, 8'h10, 8'h5A, lat);
    chk("t1_wlat", lat, 1);
    reset_dut();
    do_txn(1, 0, 8'h10, 8'h00, lat);
    chk("t1_rlat", lat, RL);
    chk("t1_din", DRAM_dataIn, 8'h5A);

    // Read and write together: write wins, error raised
    reset_dut();
    do_txn(1, 1, 8'h05, 8'h33, lat);
    chk("t3_lat", lat, 1);
    chk("t3_err", memERR, 1);
    chk("t3_din", DRAM_dataIn, 0);
    do_txn(1, 0, 8'h05, 8'h00, lat);
    chk("t3_rd", DRAM_dataIn, 8'h33);

    reset_dut();
    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_din", i), DRAM_dataIn, tbl[i].din);
      chk($sformatf("tbl%0d_err", i), memERR, tbl[i].err);
    end

    // Strobe while reading is ignored but flagged
    reset_dut();
    do_txn(0, 1, 8'h30, 8'h5C, lat);
    do_txn(0, 1, 8'h31, 8'h77, lat);
    memREAD = 1'b1;
    DRAM_addr = 8'h30;
    @(posedge Clk);
    #1;
    memREAD = 1'b0;
    memWRITE = 1'b1;
    DRAM_addr = 8'h31;
    DRAM_dataOut = 8'hEE;
    @(posedge Clk);
    #1;
    memWRITE = 1'b0;
    chk("t5_err", memERR, 1);
    lat = 99;
    for (int i = 2; i <= 20; i++) begin
      @(posedge Clk);
      #1;
      if (memRDY) begin
        lat = i;
        break;
      end
    end
    chk("t5_lat", lat, RL);
    chk("t5_din", DRAM_dataIn, 8'h5C);
    do_txn(1, 0, 8'h31, 8'h00, lat);
    chk("t5_keep", DRAM_dataIn, 8'h77);

    // Reset while a read is pending
    memREAD = 1'b1;
    DRAM_addr = 8'h30;
    @(posedge Clk);
    #1;
    memREAD = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #2;
    chk("t5r_rdy", memRDY, 0);
    chk("t5r_busy", busy, 0);
    chk("t5r_err", memERR, 0);
    chk("t5r_din", DRAM_dataIn, 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #1;
      if (memRDY) rdy_seen++;
    end
    chk("t5r_norrdy", rdy_seen, 0);

    // Randomized traffic against the model
    reset_dut();
    for (int a = 0; a < DEP; a++) begin
      model_txn(0, 1, 8'(a), 8'($urandom));
    end
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(128, 255));
      else a = 8'($urandom_range(0, 127));
      model_txn(op == 0 || op > 4, op <= 4, a, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge Clk);
        #1;
      end
    end

`ifdef DRAM_HOST_PORT_EN
    begin
      int rdy_cyc;
      int gnt_cyc;
      logic [7:0] old40;
      reset_dut();
      old40 = mem_m[8'h40];
      memREAD = 1'b1;
      DRAM_addr = 8'h40;
      host_req = 1'b1;
      host_we = 1'b1;
      host_addr = 8'h40;
      host_wdata = 8'h3C;
      @(posedge Clk);
      #1;
      memREAD = 1'b0;
      chk("h_gnt0", host_gnt, 0);
      rdy_cyc = -1;
      gnt_cyc = -1;
      for (int i = 1; i <= 12; i++) begin
        @(posedge Clk);
        #1;
        if (memRDY && rdy_cyc < 0) rdy_cyc = i;
        if (host_gnt && gnt_cyc < 0) begin
          gnt_cyc = i;
          host_req = 1'b0;
        end
      end
      chk("h_rdy_cyc", rdy_cyc, RL);
      chk("h_gnt_cyc", gnt_cyc, RL + 1);
      chk("h_core_din", DRAM_dataIn, old40);
      mem_m[8'h40] = 8'h3C;
      host_req = 1'b1;
      host_we = 1'b0;
      @(posedge Clk);
      #1;
      host_req = 1'b0;
      chk("h_rd_gnt", host_gnt, 1);
      chk("h_rd_data", host_rdata, 8'h3C);
      chk("h_rd_busy", busy, 0);
      chk("h_rd_rdy", memRDY, 0);
      host_req = 1'b1;
      host_we = 1'b1;
      host_addr = 8'h90;
      host_wdata = 8'hAB;
      @(posedge Clk);
      #1;
      host_we = 1'b0;
      @(posedge Clk);
      #1;
      host_req = 1'b0;
      chk("h_oor_data", host_rdata, 0);
      chk("h_err", memERR, 0);
      do_txn(1, 0, 8'h10, 8'h00, lat);
      chk("h_alias", DRAM_dataIn, mem_m[8'h10]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
